// File: rtl/fifo_flex_pkg.sv
// Shared helpers for fifo_flex: width derivation and parameter legality.
package fifo_flex_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Pointer width never collapses to zero bits, even for tiny depths.
  function automatic int calc_pw(input int depth);
    return (clog2(depth) < 1) ? 1 : clog2(depth);
  endfunction

  function automatic int calc_cw(input int depth);
    return clog2(depth + 1);
  endfunction

  function automatic bit params_ok(input int depth, input int af, input int ae);
    return (depth >= 2) && (depth <= 256) &&
           (af >= 1) && (af <= depth) &&
           (ae >= 0) && (ae <= depth - 1);
  endfunction

endpackage

// File: rtl/fifo_flex_wrap_ctr.sv
// Modulo-DEPTH pointer: explicit wrap so non-power-of-2 depths work.
module fifo_flex_wrap_ctr #(
  parameter int DEPTH = 6,
  parameter int PW    = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [PW-1:0] ptr_o
);

  logic [PW-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i)
      ptr_d = '0;
    else if (inc_i)
      ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_flex.sv
// Elastic valid/ready FIFO, any depth, first-word-fall-through read port,
// occupancy count, almost flags, synchronous flush and sticky high-water mark.
module fifo_flex
  import fifo_flex_pkg::*;
#(
  parameter int DEPTH     = 6,
  parameter int WIDTH     = 8,
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1,
  localparam int PW       = calc_pw(DEPTH),
  localparam int CW       = calc_cw(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    hwm
);

  if (!params_ok(DEPTH, AF_THRESH, AE_THRESH)) begin : g_bad_params
    $error("fifo_flex: illegal DEPTH/AF_THRESH/AE_THRESH combination");
  end

  /*AUTOSVA
  fifo_xfer: in -> out
  in_val = in_val
  in_rdy = in_rdy
  [WIDTH-1:0] in_data = in_data
  [PW-1:0] in_transid = wr_ptr
  out_val = out_val
  out_rdy = out_rdy
  [WIDTH-1:0] out_data = out_data
  [PW-1:0] out_transid = rd_ptr
  */

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    hwm_q, hwm_d;
  logic             push, pop;

  // Flush masks both handshakes so nothing can complete in the flush cycle.
  assign in_rdy  = !flush && (count_q != CW'(DEPTH));
  assign out_val = !flush && (count_q != '0);
  assign push    = in_val && in_rdy;
  assign pop     = out_val && out_rdy;

  fifo_flex_wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_wr_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (push),
    .ptr_o (wr_ptr)
  );

  fifo_flex_wrap_ctr #(.DEPTH(DEPTH), .PW(PW)) u_rd_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (flush),
    .inc_i (pop),
    .ptr_o (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    if (flush)
      count_d = '0;
    else if (push && !pop)
      count_d = count_q + 1'b1;
    else if (pop && !push)
      count_d = count_q - 1'b1;
  end

  assign hwm_d = (count_d > hwm_q) ? count_d : hwm_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      hwm_q   <= '0;
    end else begin
      count_q <= count_d;
      hwm_q   <= hwm_d;
    end
  end

  // Storage is deliberately unreset; out_data is ignored while out_val is low.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr] <= in_data;
  end

  assign out_data     = mem_q[rd_ptr];
  assign count        = count_q;
  assign hwm          = hwm_q;
  assign almost_full  = (count_q >= CW'(AF_THRESH));
  assign almost_empty = (count_q <= CW'(AE_THRESH));

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex (DEPTH=6): vector table for count/flags, queue scoreboard for data.
module tb_fifo_flex;

  logic       clk, rst_n, flush, in_val, in_rdy, out_val, out_rdy;
  logic [7:0] in_data, out_data;
  logic [2:0] count, hwm;
  logic       almost_full, almost_empty;

  int nchk = 0;
  int nerr = 0;
  logic [7:0] sb[$];

  typedef struct {
    bit       rst_before;
    bit       iv, ordy, fl;
    bit [7:0] din;
    int       e_cnt, e_irdy, e_oval, e_af, e_ae, e_hwm;
  } vec_t;
  vec_t tbl[$];

  fifo_flex #(.DEPTH(6), .WIDTH(8), .AF_THRESH(5), .AE_THRESH(1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_val(in_val), .in_rdy(in_rdy), .in_data(in_data),
    .out_val(out_val), .out_rdy(out_rdy), .out_data(out_data),
    .count(count), .almost_full(almost_full), .almost_empty(almost_empty),
    .hwm(hwm)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Handshakes decided at negedge hold through the next posedge (inputs change at posedge+1).
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_val && out_rdy) begin
          if (sb.size() == 0) begin
            chk("pop_on_empty_sb", 1, 0);
          end else begin
            chk("out_data", int'(out_data), int'(sb.pop_front()));
          end
        end
        if (in_val && in_rdy) sb.push_back(in_data);
      end
    end
  end

  task automatic drive(input bit iv, input bit ordy, input bit fl, input bit [7:0] din);
    in_val = iv; out_rdy = ordy; flush = fl; in_data = din;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 8'h00);
    rst_n = 0;
    sb.delete();
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic add(input bit r, input bit iv, input bit ordy, input bit fl, input bit [7:0] din,
                     input int c, input int ir, input int ov, input int af, input int ae, input int h);
    vec_t v;
    v.rst_before = r; v.iv = iv; v.ordy = ordy; v.fl = fl; v.din = din;
    v.e_cnt = c; v.e_irdy = ir; v.e_oval = ov; v.e_af = af; v.e_ae = ae; v.e_hwm = h;
    tbl.push_back(v);
  endtask

  task automatic run_tbl();
    foreach (tbl[i]) begin
      if (tbl[i].rst_before) do_reset();
      drive(tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].din);
      @(negedge clk);
      chk($sformatf("v%0d_count", i), int'(count), tbl[i].e_cnt);
      chk($sformatf("v%0d_in_rdy", i), int'(in_rdy), tbl[i].e_irdy);
      chk($sformatf("v%0d_out_val", i), int'(out_val), tbl[i].e_oval);
      chk($sformatf("v%0d_af", i), int'(almost_full), tbl[i].e_af);
      chk($sformatf("v%0d_ae", i), int'(almost_empty), tbl[i].e_ae);
      chk($sformatf("v%0d_hwm", i), int'(hwm), tbl[i].e_hwm);
      tick();
    end
    tbl.delete();
  endtask

  initial begin
    rst_n = 1;
    drive(0, 0, 0, 8'h00);
    #2;
    rst_n = 0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_in_rdy", int'(in_rdy), 1);
    chk("rst_out_val", int'(out_val), 0);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_hwm", int'(hwm), 0);
    tick();
    tick();
    rst_n = 1;

    // Fill 6 with out_rdy=0, then drain 6 with in_val=0.
    //  rst iv or fl din     cnt irdy oval af ae hwm
    add(0, 1, 0, 0, 8'h10,  0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 8'h11,  1, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0, 8'h12,  2, 1, 1, 0, 0, 2);
    add(0, 1, 0, 0, 8'h13,  3, 1, 1, 0, 0, 3);
    add(0, 1, 0, 0, 8'h14,  4, 1, 1, 0, 0, 4);
    add(0, 1, 0, 0, 8'h15,  5, 1, 1, 1, 0, 5);
    add(0, 0, 1, 0, 8'h00,  6, 0, 1, 1, 0, 6);
    add(0, 0, 1, 0, 8'h00,  5, 1, 1, 1, 0, 6);
    add(0, 0, 1, 0, 8'h00,  4, 1, 1, 0, 0, 6);
    add(0, 0, 1, 0, 8'h00,  3, 1, 1, 0, 0, 6);
    add(0, 0, 1, 0, 8'h00,  2, 1, 1, 0, 0, 6);
    add(0, 0, 1, 0, 8'h00,  1, 1, 1, 0, 1, 6);
    add(0, 0, 0, 0, 8'h00,  0, 1, 0, 0, 1, 6);
    run_tbl();

    // Streaming through the wrap point: occupancy sticks at 1.
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 0, 8'(k));
      @(negedge clk);
      chk($sformatf("wrap%0d_count", k), int'(count), (k == 0) ? 0 : 1);
      tick();
    end
    drive(0, 1, 0, 8'h00);
    @(negedge clk);
    chk("wrap_drain_count", int'(count), 1);
    tick();
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("wrap_end_count", int'(count), 0);
    chk("wrap_end_hwm", int'(hwm), 6);
    tick();

    // Flush after 3 pushes; the post-flush word must be the only one read back.
    add(1, 1, 0, 0, 8'hA0,  0, 1, 0, 0, 1, 0);
    add(0, 1, 0, 0, 8'hA1,  1, 1, 1, 0, 1, 1);
    add(0, 1, 0, 0, 8'hA2,  2, 1, 1, 0, 0, 2);
    add(0, 1, 1, 1, 8'hA3,  3, 0, 0, 0, 0, 3);
    add(0, 1, 0, 0, 8'hA4,  0, 1, 0, 0, 1, 3);
    add(0, 0, 1, 0, 8'h00,  1, 1, 1, 0, 1, 3);
    add(0, 0, 0, 0, 8'h00,  0, 1, 0, 0, 1, 3);
    run_tbl();

    // Async reset mid-cycle with 4 words held.
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 8'h20 + 8'(k));
      tick();
    end
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("pre_rst_count", int'(count), 4);
    #2;
    rst_n = 0;
    sb.delete();
    #1;
    chk("mid_rst_count", int'(count), 0);
    chk("mid_rst_out_val", int'(out_val), 0);
    chk("mid_rst_hwm", int'(hwm), 0);
    chk("mid_rst_in_rdy", int'(in_rdy), 1);
    tick();
    rst_n = 1;
    drive(1, 0, 0, 8'h77);
    tick();
    drive(1, 0, 0, 8'h78);
    @(negedge clk);
    chk("post_rst_head", int'(out_data), 8'h77);
    tick();
    drive(0, 1, 0, 8'h00);
    tick();
    tick();
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("post_rst_count", int'(count), 0);
    tick();

    // Full with both sides active: only the pop may complete.
    for (int k = 0; k < 6; k++) begin
      drive(1, 0, 0, 8'h30 + 8'(k));
      tick();
    end
    drive(1, 1, 0, 8'h99);
    @(negedge clk);
    chk("full_count", int'(count), 6);
    chk("full_in_rdy", int'(in_rdy), 0);
    chk("full_out_val", int'(out_val), 1);
    tick();
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("after_full_count", int'(count), 5);
    chk("after_full_in_rdy", int'(in_rdy), 1);
    tick();
    drive(0, 1, 0, 8'h00);
    for (int k = 0; k < 5; k++) tick();
    drive(0, 0, 0, 8'h00);
    @(negedge clk);
    chk("final_count", int'(count), 0);
    chk("final_sb_empty", sb.size(), 0);
    chk("final_hwm", int'(hwm), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nerr);
    $finish;
  end

endmodule
